// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames sampled at mid-bit, LSB first,
// exposed as RXDATA/STATUS registers with a level interrupt.
module uart_rx #(
  parameter int DW        = 32,
  parameter int DW_UART   = 8,
  parameter int CLOCK     = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rx_i,
  input  logic          cs,
  input  logic          re,
  input  logic          addr_i,
  output logic [DW-1:0] rdata_o,
  output logic          rx_intr
);

  localparam int CPB  = CLOCK / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int IW   = $clog2(DW_UART + 1);

  localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DW_UART - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic [DW_UART-1:0]   shift_q;
  logic [DW_UART-1:0]   data_q;
  logic                 s1_q, s2_q, s3_q;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 fe_q, fe_d;

  logic rd_data, rd_stat;
  logic stop_hit, good, bad;

  assign rd_data  = cs && re && !addr_i;
  assign rd_stat  = cs && re && addr_i;
  assign stop_hit = (state_q == STOP) && (cnt_q == CNT_BIT);
  assign good     = stop_hit && s2_q;
  assign bad      = stop_hit && !s2_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
    end else begin
      s1_q <= rx_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
      unique case (state_q)
        IDLE: begin
          if (s3_q && !s2_q) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            if (!s2_q) begin
              cnt_q   <= '0;
              idx_q   <= '0;
              state_q <= DATA;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == CNT_BIT) begin
            cnt_q   <= '0;
            shift_q <= {s2_q, shift_q[DW_UART-1:1]};
            if (idx_q == IDX_LAST) state_q <= STOP;
            else idx_q <= idx_q + IW'(1);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == CNT_BIT) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (s2_q) data_q <= shift_q;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // a frame event on the same edge as a clearing read wins
  always_comb begin
    valid_d = valid_q;
    ovr_d   = ovr_q;
    fe_d    = fe_q;
    if (rd_data) valid_d = 1'b0;
    if (rd_stat) begin
      ovr_d = 1'b0;
      fe_d  = 1'b0;
    end
    if (good) valid_d = 1'b1;
    if (good && valid_q && !rd_data) ovr_d = 1'b1;
    if (bad) fe_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (addr_i) rdata_o[2:0] = {fe_q, ovr_q, valid_q};
    else rdata_o[DW_UART-1:0] = data_q;
  end

  assign rx_intr = valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: randomized frames compared
// against a register-level model of the receiver.
module tb_uart_rx;

  localparam int CPB = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx    = 1'b1;
  logic        cs    = 1'b0;
  logic        re    = 1'b0;
  logic        addr  = 1'b0;
  logic [31:0] rdata;
  logic        intr;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_data;
  logic       m_v, m_ov, m_fe;

  uart_rx #(
    .DW(32), .DW_UART(8), .CLOCK(160), .BAUD_RATE(10)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_n),
    .rx_i   (rx),
    .cs     (cs),
    .re     (re),
    .addr_i (addr),
    .rdata_o(rdata),
    .rx_intr(intr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00;
    m_v    = 1'b0;
    m_ov   = 1'b0;
    m_fe   = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      if (m_v) m_ov = 1'b1;
      m_v    = 1'b1;
      m_data = b;
    end else begin
      m_fe = 1'b1;
    end
  endtask

  task automatic model_read(input logic a, output logic [31:0] exp);
    if (a) begin
      exp  = {29'd0, m_fe, m_ov, m_v};
      m_fe = 1'b0;
      m_ov = 1'b0;
    end else begin
      exp = {24'd0, m_data};
      m_v = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic do_read(input logic a, input string name);
    logic [31:0] got, exp;
    addr = a;
    cs   = 1'b1;
    re   = 1'b1;
    #1;
    got = rdata;
    model_read(a, exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: rdata=%h expected=%h", name, got, exp);
    end
    tick();
    cs = 1'b0;
    re = 1'b0;
  endtask

  task automatic check_intr(input string name);
    checks++;
    if (intr !== m_v) begin
      failures++;
      $display("FAIL %s: rx_intr=%b expected=%b", name, intr, m_v);
    end
  endtask

  task automatic check_cleared(input string name);
    addr = 1'b0;
    #1;
    checks++;
    if (rdata !== 32'd0 || intr !== 1'b0) begin
      failures++;
      $display("FAIL %s rxdata: rdata=%h intr=%b expected 0",
               name, rdata, intr);
    end
    addr = 1'b1;
    #1;
    checks++;
    if (rdata !== 32'd0) begin
      failures++;
      $display("FAIL %s status: rdata=%h expected 0", name, rdata);
    end
    addr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    tick(3);
    check_cleared("reset");
    rst_n = 1'b1;
    tick(3);
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    check_intr("single_intr");
    do_read(1'b0, "single_rxdata");
    check_intr("single_cleared");
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(3 * CPB);
    check_intr("glitch_intr");
    do_read(1'b1, "glitch_status");
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0);
    tick(4);
    do_read(1'b1, "ferr_status");
    do_read(1'b1, "ferr_status_clr");
    check_intr("ferr_intr");
    do_read(1'b0, "ferr_rxdata");
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1);
    tick(2);
    send_frame(8'h22, 1'b1);
    model_frame(8'h22, 1'b1);
    tick(2);
    do_read(1'b1, "ovr_status");
    do_read(1'b0, "ovr_rxdata");
    do_read(1'b1, "ovr_status_clr");
  endtask

  task automatic test_back_to_back();
    send_frame(8'h55, 1'b1);
    model_frame(8'h55, 1'b1);
    fork
      send_frame(8'hAA, 1'b1);
      begin
        tick(2);
        do_read(1'b0, "b2b_first");
      end
    join
    model_frame(8'hAA, 1'b1);
    do_read(1'b0, "b2b_second");
    do_read(1'b1, "b2b_status");
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    for (int n = 0; n < 10; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      model_frame(b, stop);
      tick($urandom_range(2, 6));
      check_intr("rand_intr");
      if ($urandom_range(0, 1) == 1) do_read(1'b0, "rand_rxdata");
      if ($urandom_range(0, 2) == 0) do_read(1'b1, "rand_status");
    end
    do_read(1'b1, "rand_final_status");
    do_read(1'b0, "rand_final_rxdata");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'($urandom);
    send_frame(b, 1'b1);
    model_frame(b, 1'b1);
    tick(2);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = b[3];
    tick(CPB / 2);
    rst_n = 1'b0;
    model_reset();
    check_cleared("midframe_reset");
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2 * CPB);
    send_frame(8'h7E, 1'b1);
    model_frame(8'h7E, 1'b1);
    tick(2);
    check_intr("midframe_intr");
    do_read(1'b0, "midframe_rxdata");
    do_read(1'b1, "midframe_status");
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
